// File: rtl/sample_uart_streamer.sv
// sample_uart_streamer: buffers 10-bit filtered samples in a small FIFO and
// sends each one as two 8N1 UART bytes, flagging dropped samples.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   data_in        10-bit sample
//   strobe_in      sample valid, one sample per high cycle
//   clear_overflow pulse that clears the sticky overflow flag
//   tx_out         UART line, idle high
//   busy           transmitter not idle
//   fifo_level     samples currently stored
//   overflow       sticky flag, set when a sample was dropped
module sample_uart_streamer #(
    parameter int CLKS_PER_BIT    = 87,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [9:0]               data_in,
    input  logic                     strobe_in,
    input  logic                     clear_overflow,
    output logic                     tx_out,
    output logic                     busy,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level,
    output logic                     overflow
);

    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;
    localparam int BW    = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [BW-1:0] baud_cnt;
    logic [BW-1:0] baud_n;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_n;
    logic          byte_sel;
    logic          sel_n;
    logic          tx_n;
    logic [9:0]    frame_data;
    logic          frame_ovf;
    logic [7:0]    cur_byte;
    logic          baud_done;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          push;
    logic          drop;

    // count never exceeds DEPTH, so its MSB alone marks full
    assign fifo_full  = count[AW];
    assign fifo_empty = (count == '0);

    // A full FIFO still accepts a sample on the edge that pops one
    assign pop  = (state == IDLE) && !fifo_empty;
    assign push = strobe_in && (!fifo_full || pop);
    assign drop = strobe_in && !push;

    assign baud_done = (baud_cnt == '0);

    // Byte 1 carries a bit7 marker so the host can find byte pairs
    assign cur_byte = byte_sel
                    ? {1'b1, frame_ovf, 4'b0000, frame_data[9:8]}
                    : frame_data[7:0];

    assign busy       = (state != IDLE);
    assign fifo_level = count;

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt - BW'(1);
        bit_n   = bit_idx;
        sel_n   = byte_sel;
        tx_n    = 1'b1;
        unique case (state)
            IDLE: begin
                baud_n = BAUD_LAST;
                if (pop) begin
                    state_n = START;
                    sel_n   = 1'b0;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (baud_done) begin
                    state_n = DATA;
                    baud_n  = BAUD_LAST;
                    bit_n   = 3'd0;
                end
            end
            DATA: begin
                tx_n = cur_byte[bit_idx];
                if (baud_done) begin
                    baud_n = BAUD_LAST;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (baud_done) begin
                    baud_n = BAUD_LAST;
                    if (!byte_sel) begin
                        sel_n   = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // tx_out is the registered image of the state held in the prior cycle,
    // so the line lags the FSM by one clock and never glitches
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= BAUD_LAST;
            bit_idx  <= 3'd0;
            byte_sel <= 1'b0;
            tx_out   <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            byte_sel <= sel_n;
            tx_out   <= tx_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_data <= '0;
            frame_ovf  <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            if (pop) begin
                frame_data <= mem[rd_ptr];
                frame_ovf  <= overflow;
                rd_ptr     <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            // A drop wins over a simultaneous clear
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: doc/sample_uart_streamer.md
Name: sample_uart_streamer

Overview:
- Downstream consumer of the moving-average filter output: takes the 10-bit filtered sample and its one-cycle strobe.
- Buffers samples in a small FIFO and streams each one off-chip as two standard 8N1 UART bytes on a single pin.
- Flags dropped samples so the host can detect FIFO overrun.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit period (87 gives ~115200 baud at 10 MHz); legal range >= 2.
- FIFO_DEPTH_LOG2, 2, log2 of FIFO depth (default depth 4); legal range >= 1.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  10  filtered sample.
- strobe_in  input  1  sample valid; every cycle it is high counts as one sample.
- clear_overflow  input  1  one-cycle pulse that clears the sticky overflow flag.
- tx_out  output  1  UART serial line, idle high.
- busy  output  1  high whenever the FSM is not in IDLE.
- fifo_level  output  FIFO_DEPTH_LOG2+1  number of samples currently stored.
- overflow  output  1  sticky flag, set when a sample was dropped.

Behaviour:
- Clock/reset: one clock (clk). reset is synchronous and active-high.
- Reset values:
  - tx_out=1, busy=0, fifo_level=0, overflow=0.
  - FSM in IDLE, FIFO pointers zeroed.
  - Reset asserted mid-frame aborts the frame: tx_out is 1 from the next edge, and FIFO contents are discarded.
- FIFO write:
  - On each edge with strobe_in=1, data_in is written if the FIFO is not full after this cycle's pop.
  - Otherwise the sample is dropped and overflow is set.
  - If a push and a pop occur in the same cycle while full, the push is accepted; fifo_level is unchanged.
- Overflow flag:
  - clear_overflow=1 clears it.
  - A drop in the same cycle as clear_overflow leaves overflow=1 (set wins).
- FSM states: IDLE, START, DATA, STOP, plus a 1-bit byte_sel register.
- IDLE:
  - If the FIFO is non-empty: pop one sample and latch it into the frame register.
  - Byte 0 = data[7:0].
  - Byte 1 = {1'b1, ovf, 4'b0000, data[9:8]}, where ovf is the value of overflow at the pop edge.
  - Set byte_sel=0 and go to START.
- START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: 8 bits, LSB first, each held exactly CLKS_PER_BIT cycles; a 3-bit index counts the bits. Then go to STOP.
- STOP:
  - tx_out=1 for CLKS_PER_BIT cycles.
  - If byte_sel=0: set byte_sel=1 and go to START (byte 1 follows with no idle gap).
  - Else: go to IDLE.
- Bit timing:
  - A baud counter reloads at each state/bit change.
  - tx_out is registered and glitch-free.
- Latency:
  - Strobe sampled at edge E0 into an empty FIFO with the FSM in IDLE: pop at E1, tx_out low from E2.
  - One sample occupies exactly 20*CLKS_PER_BIT cycles from start-bit edge to end of the byte-1 stop bit.
  - Back-to-back samples are separated by exactly one IDLE cycle of tx_out=1.
- Framing: byte 1 bit7=1 and byte 0 is unconstrained; the host resynchronises on byte pairs using the bit7 marker of byte 1.
- fifo_level is updated on the same edge as the push or pop.

Test Plan:
- Single sample, CLKS_PER_BIT=4:
  - Stimulus: reset, then one strobe with data_in=10'h2A5.
  - Required: tx_out low from E2; decoded bytes 0xA5 then 0x82; 80 cycles of frame; busy falls 1 cycle after the final stop bit; overflow=0.
- Bit timing, CLKS_PER_BIT=5:
  - Stimulus: data_in=10'h155.
  - Required: every bit period exactly 5 cycles; bytes 0x55 then 0x81; no idle cycle between the two bytes.
- Overflow burst, depth 4:
  - Stimulus: strobes on 6 consecutive cycles with values 1..6.
  - Required: sample 6 is dropped; overflow=1 from E5; fifo_level peaks at 4.
  - Required: 5 samples transmitted in order 1..5; sample 1 byte 1 = 0x80; samples 2–5 byte 1 = 0xC0.
- Clear vs drop collision:
  - Stimulus: FIFO full, strobe_in and clear_overflow asserted in the same cycle.
  - Required: overflow stays 1; a later lone clear_overflow pulse gives overflow=0 on the next edge.
- Push/pop collision:
  - Stimulus: FIFO full with FSM in IDLE, strobe_in high on the pop edge.
  - Required: sample accepted, fifo_level stays 4, overflow stays 0.
- Reset mid-frame:
  - Stimulus: assert reset during DATA of byte 0 with 2 samples queued.
  - Required: next edge tx_out=1, busy=0, fifo_level=0, overflow=0; no further transmission until a new strobe.
